// File: rtl/fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : fifo_if
// Brief    : Handshake bundle between a producer/consumer and sync_fifo.
//            Optional error flags present when SYNC_FIFO_ERR_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface fifo_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  wr;
   logic                  rd;
   logic [DATA_WIDTH-1:0] din;
   logic [DATA_WIDTH-1:0] dout;
   logic                  empty;
   logic                  full;
`ifdef SYNC_FIFO_ERR_EN
   logic                  overflow;
   logic                  underflow;

   modport master (
      output wr, rd, din,
      input  dout, empty, full, overflow, underflow
   );

   modport slave (
      input  wr, rd, din,
      output dout, empty, full, overflow, underflow
   );
`else
   modport master (
      output wr, rd, din,
      input  dout, empty, full
   );

   modport slave (
      input  wr, rd, din,
      output dout, empty, full
   );
`endif
endinterface
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Brief    : Single-clock FIFO with registered read port and full/empty flags.
//            Define SYNC_FIFO_ERR_EN to add sticky overflow/underflow outputs.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16
) (
   input  wire logic clk,
   input  wire logic rst,
   fifo_if.slave     bus
);

   localparam int c_addr_w  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int c_count_w = c_addr_w + 1;
   localparam logic [c_count_w-1:0] c_full_count = c_count_w'(DEPTH);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [c_addr_w-1:0]   r_wptr;
   logic [c_addr_w-1:0]   r_rptr;
   logic [c_count_w-1:0]  r_count;
   logic [DATA_WIDTH-1:0] r_dout;

   logic w_empty;
   logic w_full;
   logic w_wr_ok;
   logic w_rd_ok;

   // Flags come straight from the registered occupancy, so they can never
   // both be high and only move on an edge or on reset.
   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == c_full_count);
   assign w_wr_ok = bus.wr & ~w_full;
   assign w_rd_ok = bus.rd & ~w_empty;

   assign bus.empty = w_empty;
   assign bus.full  = w_full;
   assign bus.dout  = r_dout;

   // Storage is deliberately not reset; stale contents are unreachable once
   // the pointers and count are cleared.
   always_ff @(posedge clk) begin
      if (w_wr_ok) begin
         r_mem[r_wptr] <= bus.din;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_dout  <= '0;
      end else begin
         if (w_wr_ok) begin
            r_wptr <= r_wptr + 1'b1;
         end
         if (w_rd_ok) begin
            r_dout <= r_mem[r_rptr];
            r_rptr <= r_rptr + 1'b1;
         end
         case ({w_wr_ok, w_rd_ok})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

`ifdef SYNC_FIFO_ERR_EN
   logic r_overflow;
   logic r_underflow;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (bus.wr && w_full) begin
            r_overflow <= 1'b1;
         end
         if (bus.rd && w_empty) begin
            r_underflow <= 1'b1;
         end
      end
   end

   assign bus.overflow  = r_overflow;
   assign bus.underflow = r_underflow;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_fifo
// Brief    : Self-checking bench for sync_fifo against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_fifo;

   localparam int DW    = 8;
   localparam int DEPTH = 16;

   logic clk;
   logic rst;

   fifo_if #(.DATA_WIDTH(DW)) bus ();

   sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [DW-1:0] q[$];
   logic [DW-1:0] m_dout;
   logic          m_ovf;
   logic          m_unf;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".empty"}, 32'(bus.empty), 32'(q.size() == 0));
      check({tag, ".full"},  32'(bus.full),  32'(q.size() == DEPTH));
      check({tag, ".dout"},  32'(bus.dout),  32'(m_dout));
`ifdef SYNC_FIFO_ERR_EN
      check({tag, ".overflow"},  32'(bus.overflow),  32'(m_ovf));
      check({tag, ".underflow"}, 32'(bus.underflow), 32'(m_unf));
`endif
   endtask

   task automatic model_reset();
      q.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
   endtask

   // One clock of traffic: model updated from the request, then DUT checked #1 after the edge.
   task automatic step(input logic w, input logic r, input logic [DW-1:0] d, input string tag);
      logic wr_ok, rd_ok;
      bus.wr  = w;
      bus.rd  = r;
      bus.din = d;
      wr_ok = w && (q.size() < DEPTH);
      rd_ok = r && (q.size() != 0);
      if (w && q.size() == DEPTH) m_ovf = 1'b1;
      if (r && q.size() == 0)     m_unf = 1'b1;
      if (rd_ok) m_dout = q.pop_front();
      if (wr_ok) q.push_back(d);
      @(posedge clk);
      #1;
      bus.wr = 1'b0;
      bus.rd = 1'b0;
      check_all(tag);
   endtask

   initial begin
      rst     = 1'b0;
      bus.wr  = 1'b0;
      bus.rd  = 1'b0;
      bus.din = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      @(negedge clk);
      rst = 1'b1;

      // Read while empty
      step(1'b0, 1'b1, 8'h00, "rd_empty");

      // Fill and drain
      for (int i = 1; i <= DEPTH; i++) step(1'b1, 1'b0, DW'(i), "fill");
      step(1'b1, 1'b0, 8'hFF, "wr_full");
      for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 8'h00, "drain");

      // Simultaneous when full: read wins, write of 0x77 dropped
      for (int i = 1; i <= DEPTH; i++) step(1'b1, 1'b0, DW'(8'h30 + i), "refill");
      step(1'b1, 1'b1, 8'h77, "wrrd_full");
      for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 8'h00, "drain_after_full");

      // Simultaneous when empty, then with 5 entries
      step(1'b1, 1'b1, 8'h55, "wrrd_empty");
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, DW'(8'h60 + i), "load5");
      step(1'b1, 1'b1, 8'h64, "wrrd_five");
      for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 8'h00, "drain5");

      // Wrap-around
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, DW'(i), "wrap_w10");
      for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'h00, "wrap_r10");
      for (int i = 0; i < 12; i++) step(1'b1, 1'b0, DW'(8'hA0 + i), "wrap_w12");
      for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 8'h00, "wrap_r12");

      // Asynchronous reset mid-burst
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, DW'(8'hC0 + i), "pre_rst");
      step(1'b0, 1'b1, 8'h00, "pre_rst_rd");
      #2;
      rst = 1'b0;
      model_reset();
      #1;
      check_all("async_rst");
      bus.wr  = 1'b1;
      bus.din = 8'hEE;
      @(posedge clk);
      #1;
      bus.wr = 1'b0;
      check_all("rst_held");
      #2;
      rst = 1'b1;
      step(1'b0, 1'b1, 8'h00, "post_rst_rd");

      // Random traffic
      for (int i = 0; i < 30; i++) begin
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), DW'($urandom), "random");
      end
      while (q.size() != 0) step(1'b0, 1'b1, 8'h00, "final_drain");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
